// File: rtl/reg_file_pkg.sv
// Widths shared by the decode, execute and write-back stages so that
// every stage agrees on register address and data sizes.
package reg_file_pkg;

  localparam int REG_FILE_ADDR_LEN = 4;
  localparam int REG_FILE_SIZE     = 32;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// Combinational read mux over the flattened register array.
// Optionally forces register 0 to read as zero.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int ADDR_LEN   = REG_FILE_ADDR_LEN,
  parameter int DATA_WIDTH = REG_FILE_SIZE,
  parameter int ZERO_REG   = 0
) (
  input  logic [(2**ADDR_LEN)*DATA_WIDTH-1:0] regs,
  input  logic [ADDR_LEN-1:0]                 addr,
  output logic [DATA_WIDTH-1:0]               data
);

  always_comb begin
    data = regs[int'(addr)*DATA_WIDTH +: DATA_WIDTH];
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// ID-stage register file: two combinational read ports, one synchronous
// write port, async active-low clear of every register.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ADDR_LEN   = REG_FILE_ADDR_LEN,
  parameter int DATA_WIDTH = REG_FILE_SIZE,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic [ADDR_LEN-1:0]   src1,
  input  logic [ADDR_LEN-1:0]   src2,
  input  logic [ADDR_LEN-1:0]   dest,
  input  logic [DATA_WIDTH-1:0] writeVal,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2
);

  localparam int DEPTH = 2**ADDR_LEN;

  logic [DATA_WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] regs_flat;
  logic                        write_ok;

  // Register 0 is hardwired when ZERO_REG is set, so its writes are dropped.
  assign write_ok = writeEn && !((ZERO_REG != 0) && (dest == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[dest] <= writeVal;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  reg_file_read_port #(
    .ADDR_LEN  (ADDR_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_read1 (
    .regs(regs_flat),
    .addr(src1),
    .data(reg1)
  );

  reg_file_read_port #(
    .ADDR_LEN  (ADDR_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_read2 (
    .regs(regs_flat),
    .addr(src2),
    .data(reg2)
  );

  a_write_en_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(writeEn))
    else $error("writeEn unknown at clock edge");

  a_read_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown({reg1, reg2}))
    else $error("read data unknown after reset");

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Randomized self-checking bench: a plain and a ZERO_REG=1 instance share
// stimulus and are compared against an array model of the register file.
module tb_reg_file;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          rst;
  logic          writeEn;
  logic [AW-1:0] src1, src2, dest;
  logic [DW-1:0] writeVal;
  logic [DW-1:0] r1_a, r2_a, r1_z, r2_z;

  int vectors = 0;
  int errors  = 0;

  // Model: one plain array per instance flavour.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_z [DEPTH];

  reg_file #(.ADDR_LEN(AW), .DATA_WIDTH(DW), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .writeEn(writeEn), .src1(src1), .src2(src2),
    .dest(dest), .writeVal(writeVal), .reg1(r1_a), .reg2(r2_a)
  );

  reg_file #(.ADDR_LEN(AW), .DATA_WIDTH(DW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .writeEn(writeEn), .src1(src1), .src2(src2),
    .dest(dest), .writeVal(writeVal), .reg1(r1_z), .reg2(r2_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] model_rd(input int z, input int a);
    if (z != 0) return (a == 0) ? '0 : mem_z[a];
    return mem_a[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_z[i] = '0;
    end
  endtask

  // Advance one edge, updating the model as the write port should, then
  // settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst && writeEn) begin
      mem_a[dest] = writeVal;
      if (dest != 0) mem_z[dest] = writeVal;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; writeEn = 1'b0; dest = '0; writeVal = '0;
    src1 = AW'($urandom); src2 = AW'($urandom);
    model_clear();
    #3;
    vectors++;
    if (r1_a !== '0 || r2_a !== '0 || r1_z !== '0 || r2_z !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h %h want 0", r1_a, r2_a, r1_z, r2_z);
    end
    tick();
    #2 rst = 1'b1;
    // Write in flight, then reset asserted before its edge.
    writeEn = 1'b1; dest = 4'd3; writeVal = 32'hABCD_1234; src1 = 4'd3; src2 = 4'd3;
    #1 rst = 1'b0;
    tick();
    vectors++;
    if (r1_a !== '0 || r2_z !== '0) begin
      errors++;
      $display("FAIL reset_over_write: got %h %h want 0", r1_a, r2_z);
    end
    #2 rst = 1'b1; writeEn = 1'b0;
  endtask

  task automatic test_basic();
    writeEn = 1'b1; dest = 4'd1; writeVal = 32'd2; src1 = 4'd1; src2 = 4'd2;
    #1;
    vectors++;
    if (r1_a !== 32'd0) begin
      errors++;
      $display("FAIL basic_pre_edge: got %h want 0", r1_a);
    end
    tick();
    vectors++;
    if (r1_a !== 32'd2 || r2_a !== 32'd0 || r1_z !== 32'd2) begin
      errors++;
      $display("FAIL basic_post_edge: got %h %h %h want 2 0 2", r1_a, r2_a, r1_z);
    end
  endtask

  task automatic test_write_disable();
    writeEn = 1'b0; dest = 4'd1; writeVal = 32'd6; src1 = 4'd1;
    tick();
    tick();
    vectors++;
    if (r1_a !== 32'd2 || r1_z !== 32'd2) begin
      errors++;
      $display("FAIL write_disable: got %h %h want 2", r1_a, r1_z);
    end
  endtask

  task automatic test_overwrite();
    writeEn = 1'b1; dest = 4'd2; writeVal = 32'd8; src1 = 4'd1; src2 = 4'd2;
    tick();
    vectors++;
    if (r2_a !== 32'd8 || r1_a !== 32'd2) begin
      errors++;
      $display("FAIL overwrite_first: got %h %h want 8 2", r2_a, r1_a);
    end
    writeVal = 32'd9;
    tick();
    vectors++;
    if (r2_a !== 32'd9 || r2_z !== 32'd9) begin
      errors++;
      $display("FAIL overwrite_second: got %h %h want 9", r2_a, r2_z);
    end
  endtask

  task automatic test_same_addr();
    src1 = 4'd2; src2 = 4'd2; dest = 4'd2; writeVal = 32'd5; writeEn = 1'b1;
    #1;
    vectors++;
    if (r1_a !== 32'd9 || r2_a !== 32'd9) begin
      errors++;
      $display("FAIL same_addr_no_bypass: got %h %h want 9 9", r1_a, r2_a);
    end
    tick();
    vectors++;
    if (r1_a !== 32'd5 || r2_a !== 32'd5 || r1_z !== 32'd5 || r2_z !== 32'd5) begin
      errors++;
      $display("FAIL same_addr_post: got %h %h %h %h want 5", r1_a, r2_a, r1_z, r2_z);
    end
    writeEn = 1'b0;
  endtask

  task automatic test_zero_reg();
    writeEn = 1'b1; dest = 4'd0; writeVal = 32'hFFFF_FFFF; src1 = 4'd0; src2 = 4'd0;
    tick();
    vectors++;
    if (r1_z !== 32'd0 || r2_z !== 32'd0) begin
      errors++;
      $display("FAIL zero_reg_masked: got %h %h want 0", r1_z, r2_z);
    end
    vectors++;
    if (r1_a !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL plain_reg0_writable: got %h want ffffffff", r1_a);
    end
    writeEn = 1'b0;
  endtask

  task automatic test_sweep();
    writeEn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      dest = AW'(i); writeVal = DW'(i);
      tick();
    end
    writeEn = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      src1 = AW'(i); src2 = AW'(DEPTH - 1 - i);
      #1;
      vectors++;
      if (r1_a !== DW'(i) || r2_a !== DW'(DEPTH - 1 - i) ||
          r1_z !== ((i == 0) ? '0 : DW'(i)) ||
          r2_z !== ((i == DEPTH - 1) ? '0 : DW'(DEPTH - 1 - i))) begin
        errors++;
        $display("FAIL sweep[%0d]: got %h %h %h %h", i, r1_a, r2_a, r1_z, r2_z);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      writeEn = 1'($urandom);
      dest = AW'($urandom); writeVal = $urandom;
      src1 = ($urandom_range(0, 3) == 0) ? dest : AW'($urandom);
      src2 = AW'($urandom);
      #1;
      vectors++;
      if (r1_a !== model_rd(0, src1) || r2_a !== model_rd(0, src2) ||
          r1_z !== model_rd(1, src1) || r2_z !== model_rd(1, src2)) begin
        errors++;
        $display("FAIL random_pre[%0d]: got %h %h %h %h want %h %h %h %h", n,
                 r1_a, r2_a, r1_z, r2_z, model_rd(0, src1), model_rd(0, src2),
                 model_rd(1, src1), model_rd(1, src2));
      end
      tick();
      vectors++;
      if (r1_a !== model_rd(0, src1) || r2_a !== model_rd(0, src2) ||
          r1_z !== model_rd(1, src1) || r2_z !== model_rd(1, src2)) begin
        errors++;
        $display("FAIL random_post[%0d]: got %h %h %h %h want %h %h %h %h", n,
                 r1_a, r2_a, r1_z, r2_z, model_rd(0, src1), model_rd(0, src2),
                 model_rd(1, src1), model_rd(1, src2));
      end
      // Occasional mid-cycle reset pulse.
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        model_clear();
        #2;
        vectors++;
        if (r1_a !== '0 || r2_a !== '0 || r1_z !== '0 || r2_z !== '0) begin
          errors++;
          $display("FAIL random_reset[%0d]: got %h %h %h %h want 0", n, r1_a, r2_a, r1_z, r2_z);
        end
        rst = 1'b1;
      end
    end
    writeEn = 1'b0;
  endtask

  initial begin
    rst = 1'b0; writeEn = 1'b0; src1 = '0; src2 = '0; dest = '0; writeVal = '0;
    model_clear();
    test_reset();
    test_basic();
    test_write_disable();
    test_overwrite();
    test_same_addr();
    test_zero_reg();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the CPU's ID (instruction decode) stage.
- Two asynchronous (combinational) read ports feed the operand latches.
- One synchronous write port is driven by the write-back stage.
- Every register clears to zero on reset.

Parameters:
- ADDR_LEN, default `REG_FILE_ADDR_LEN (4): width of each register address; depth = 2**ADDR_LEN entries.
- DATA_WIDTH, default `REG_FILE_SIZE (32): width of each register and of all data ports.
- ZERO_REG, default 0: when 1, register 0 reads as 0 and ignores writes; when 0, register 0 behaves like any other register.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all registers immediately.
- writeEn  input  1  write enable for the write port.
- src1  input  ADDR_LEN  read address, port 1.
- src2  input  ADDR_LEN  read address, port 2.
- dest  input  ADDR_LEN  write address.
- writeVal  input  DATA_WIDTH  write data.
- reg1  output  DATA_WIDTH  contents of register src1.
- reg2  output  DATA_WIDTH  contents of register src2.

Behaviour:
- Storage: array of 2**ADDR_LEN registers, each DATA_WIDTH bits.
- Reset:
  - rst=0 asynchronously sets every register to 0, so reg1=reg2=0 while reset is held.
  - Reset deassertion is sampled with no extra latency; the first rising edge with rst=1 may write.
  - Reset asserted mid-write overrides the write; the target register ends at 0.
- Write:
  - On a rising clk edge with rst=1 and writeEn=1, register[dest] <= writeVal.
  - writeEn=0: no register changes, regardless of dest or writeVal.
  - writeEn, dest and writeVal are sampled only at the edge; changes between edges have no effect.
- Read:
  - Purely combinational: reg1 = register[src1], reg2 = register[src2].
  - Outputs change in the same cycle that src1/src2 change.
  - There is no write-to-read bypass. A read of dest during the write cycle returns the old value until the edge, then the new value.
- Both read ports may address the same register, including dest, simultaneously; both return identical data.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - reg1/reg2 return 0 whenever src1/src2 is 0.
- Address width equals the full index range, so there are no out-of-range addresses and no wrap-around handling.
- X on writeEn while rst=1 is an illegal input. Verification flags it with an assertion; RTL behaviour is undefined.
- Assertions in RTL, simulation only:
  - no X on reg1/reg2 after reset completes;
  - writeEn known at every rising edge with rst=1.

Decomposition:
- Shared package/defines file holds REG_FILE_ADDR_LEN (4) and REG_FILE_SIZE (32), so decode, execute and write-back stages agree on widths.
- One natural sub-module, reg_file_read_port: a combinational mux of DATA_WIDTH bits from 2**ADDR_LEN inputs, with ZERO_REG masking. It is instantiated twice, for reg1 and reg2.
- The write decode and storage array stay in the top module.

Test Plan:
- Reset: drive rst=0 for 1 cycle with arbitrary src1/src2 -> reg1=reg2=0. Assert rst=0 mid-cycle with writeEn=1 -> target register stays 0.
- Basic write/read:
  - Stimulus: rst=1, writeEn=1, dest=1, writeVal=2, src1=1, src2=2.
  - Before the edge: reg1=0.
  - After the rising edge: reg1=2, reg2=0.
- Write disable: writeEn=0, dest=1, writeVal=6 for 2 edges -> reg1 remains 2.
- Overwrite:
  - writeEn=1, dest=2, writeVal=8 -> after the edge, reg2=8 and reg1=2.
  - Next edge with writeVal=9 -> reg2=9.
- Same-address dual read: src1=src2=2 while dest=2, writeVal=5, writeEn=1 -> both outputs 9 before the edge, both 5 after. Confirms no bypass.
- ZERO_REG=1 build: write dest=0, writeVal=0xFFFF_FFFF -> reg1=0 with src1=0. Full sweep writing value=index to all 16 registers reads back correctly on both ports.
